traffic_phase_ctrl: RTL and testbench
=====================================

// Module: traffic_phase_ctrl
// PURPOSE
//  Phase sequencer for the two-road traffic-light intersection. Drives the countdown timer:
//  sets its enable and per-phase duration, and advances phase on the timer's reload flag.
//  Decodes the current phase into NS/EW lamp outputs. Sits directly upstream of the
//  countdown timer. Also consumes that timer's flag_re.
// PARAMETERS
//  T_NS_G   30  north-south green duration, timer ticks (1..63)
//  T_EW_G   20  east-west green duration, timer ticks (1..63)
//  T_Y       3  yellow duration, both roads (1..63)
//  T_RED     2  all-red clearance duration (1..63)
// PORTS
//  clk         in   1  system tick clock (same clock as the timer)
//  rst_N       in   1  asynchronous, active-low reset
//  run         in   1  1 = cycle phases; 0 = hold all-red
//  night_mode  in   1  1 = flashing-yellow mode; takes priority over run
//  flag_re     in   1  timer reload flag; high while timer count == 1
//  timer_en    out  1  timer enable
//  count_num   out  6  duration for the current/next phase, to timer
//  light_ns    out  3  {R,Y,G} north-south lamps, one-hot or 000
//  light_ew    out  3  {R,Y,G} east-west lamps, one-hot or 000
//  phase       out  3  encoded state, for display/debug
// BEHAVIOUR
//  - States: IDLE, AR_A (all-red before NS), NS_G, NS_Y, AR_B (all-red before EW),
//    EW_G, EW_Y, NIGHT.
//  - Reset: state=IDLE, timer_en=0, count_num=T_RED, blink=0,
//    light_ns=light_ew=3'b100.
//  - Moore machine. All outputs decode from the state register and blink register only.
//    No combinational path from inputs to outputs.
//  - Priority each edge: night_mode > !run > phase advance.
//  - night_mode=1 from any state -> NIGHT next edge.
//    NIGHT behaviour: timer_en=0; blink toggles every clk; lamps={0,blink,0} on both roads.
//    blink=0 on entry.
//  - NIGHT with night_mode=0 -> AR_A. Red clearance is always taken before green.
//  - run=0 (night_mode=0) from any state -> IDLE next edge.
//    IDLE behaviour: all-red, timer_en=0, count_num=T_RED (timer preloads).
//  - IDLE with run=1 -> AR_A.
//  - Cycling: AR_A->NS_G->NS_Y->AR_B->EW_G->EW_Y->AR_A.
//    Advance only on an edge where timer_en=1 and flag_re=1. Otherwise hold.
//  - count_num is registered from the next state, so it is valid before the timer's
//    reload edge (timer counts 1->0 on the advance edge, then reloads one edge later).
//  - count_num values: T_RED in AR_A/AR_B/IDLE, T_NS_G in NS_G, T_Y in NS_Y/EW_Y,
//    T_EW_G in EW_G. count_num=0 in NIGHT.
//  - Steady state: each phase occupies its duration+1 clocks.
//  - timer_en=1 in all cycling states, 0 in IDLE/NIGHT.
//  - Lamps: NS_G ns=001 ew=100; NS_Y ns=010 ew=100; EW_G ew=001 ns=100;
//    EW_Y ew=010 ns=100; AR_x/IDLE both 100.
//  - Safety invariant: green or yellow is never shown on both roads simultaneously.
//  - flag_re while timer_en=0 is ignored.
//  - Reset mid-phase: immediate IDLE outputs.
//  - Illegal state encoding: recover to IDLE next edge.
//  - Parameters outside 1..63: elaboration error (generate-time check).
// STRUCTURE
//  - Shared package tl_pkg: state localparams, lamp codes (LAMP_R/Y/G/OFF),
//    default durations. Reused by the timer bench and the display path.
//  - Optional sub-module tl_lamp_decode (state, blink -> light_ns, light_ew).
//    Everything else stays in one always block for state/count_num/blink.
// TESTING (bench instantiates this block plus the companion timer)
//  1 Reset, then run=1, night_mode=0 -> AR_A, then NS_G with count_num=30.
//    NS_G lasts 31 clks, then NS_Y count_num=3.
//  2 Full cycle with defaults -> exact order AR_A,NS_G,NS_Y,AR_B,EW_G,EW_Y,AR_A.
//    Period = (2+1)*2 + (30+1) + (20+1) + (3+1)*2 = 66 clks.
//  3 night_mode=1 mid NS_G -> NIGHT next edge; timer_en=0; yellow toggles 1,0,1...
//    on both roads. Release -> AR_A, then NS_G.
//  4 run=0 during EW_Y -> IDLE next edge, all-red, count_num=2.
//    night_mode and run=0 asserted together -> NIGHT.
//  5 Force flag_re=1 with timer_en=0 (IDLE) -> no transition.
//    flag_re pulse in NS_G -> exactly one advance.
//  6 Assert rst_N low mid EW_G -> outputs reset values asynchronously.
//    Concurrent assertion checks both-roads-not-green and lamp one-hot every cycle.

Source files
------------

// File: rtl/tl_pkg.sv
// Shared definitions for the traffic-light intersection: phase encoding,
// lamp codes and default phase durations.
package tl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    AR_A  = 3'd1,
    NS_G  = 3'd2,
    NS_Y  = 3'd3,
    AR_B  = 3'd4,
    EW_G  = 3'd5,
    EW_Y  = 3'd6,
    NIGHT = 3'd7
  } state_t;

  // Lamp codes are {R,Y,G}.
  localparam logic [2:0] LAMP_R   = 3'b100;
  localparam logic [2:0] LAMP_Y   = 3'b010;
  localparam logic [2:0] LAMP_G   = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  localparam int DEF_T_NS_G = 30;
  localparam int DEF_T_EW_G = 20;
  localparam int DEF_T_Y    = 3;
  localparam int DEF_T_RED  = 2;

  // A duration must fit the 6-bit timer load and be non-zero.
  function automatic bit dur_ok(input int d);
    return (d >= 1) && (d <= 63);
  endfunction

endpackage

// File: rtl/tl_lamp_decode.sv
// Decodes the phase register and night blink bit into the lamp drives
// for both roads.
module tl_lamp_decode
  import tl_pkg::*;
(
  input  logic [2:0] state,
  input  logic       blink,
  output logic [2:0] light_ns,
  output logic [2:0] light_ew
);

  // NOTE: every output gets a default before the case so no path leaves it
  // unassigned; that is what keeps this block free of inferred latches.
  always_comb begin
    light_ns = LAMP_R;
    light_ew = LAMP_R;
    case (state_t'(state))
      NS_G:    light_ns = LAMP_G;
      NS_Y:    light_ns = LAMP_Y;
      EW_G:    light_ew = LAMP_G;
      EW_Y:    light_ew = LAMP_Y;
      NIGHT: begin
        light_ns = blink ? LAMP_Y : LAMP_OFF;
        light_ew = blink ? LAMP_Y : LAMP_OFF;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Phase sequencer for a two-road intersection. Steps through the light
// phases on the countdown timer's reload flag and loads its next duration.
module traffic_phase_ctrl
  import tl_pkg::*;
#(
  parameter int T_NS_G = DEF_T_NS_G,
  parameter int T_EW_G = DEF_T_EW_G,
  parameter int T_Y    = DEF_T_Y,
  parameter int T_RED  = DEF_T_RED
) (
  input  logic       clk,
  input  logic       rst_N,
  input  logic       run,
  input  logic       night_mode,
  input  logic       flag_re,
  output logic       timer_en,
  output logic [5:0] count_num,
  output logic [2:0] light_ns,
  output logic [2:0] light_ew,
  output logic [2:0] phase
);

  generate
    if (!(dur_ok(T_NS_G) && dur_ok(T_EW_G) && dur_ok(T_Y) && dur_ok(T_RED))) begin : g_bad_duration
      $error("traffic_phase_ctrl: every duration must lie in 1..63");
    end
  endgenerate

  localparam logic [5:0] CNT_NS_G = 6'(T_NS_G);
  localparam logic [5:0] CNT_EW_G = 6'(T_EW_G);
  localparam logic [5:0] CNT_Y    = 6'(T_Y);
  localparam logic [5:0] CNT_RED  = 6'(T_RED);

  state_t     state;
  state_t     state_nxt;
  logic       blink;
  logic       blink_nxt;
  logic [5:0] count_nxt;
  logic       advance;

  assign timer_en = state inside {AR_A, NS_G, NS_Y, AR_B, EW_G, EW_Y};
  assign advance  = timer_en & flag_re;
  assign phase    = 3'(state);

  always_comb begin
    state_nxt = state;
    if (night_mode) begin
      state_nxt = NIGHT;
    end else if (!run) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = AR_A;
        NIGHT:   state_nxt = AR_A;
        AR_A:    if (advance) state_nxt = NS_G;
        NS_G:    if (advance) state_nxt = NS_Y;
        NS_Y:    if (advance) state_nxt = AR_B;
        AR_B:    if (advance) state_nxt = EW_G;
        EW_G:    if (advance) state_nxt = EW_Y;
        EW_Y:    if (advance) state_nxt = AR_A;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Blink restarts at 0 whenever NIGHT is entered, then toggles each clock.
  always_comb begin
    blink_nxt = 1'b0;
    if (state == NIGHT && state_nxt == NIGHT) blink_nxt = ~blink;
  end

  // Loaded from the next state so the timer sees the new duration before
  // its reload edge, one clock after the advance.
  always_comb begin
    count_nxt = CNT_RED;
    case (state_nxt)
      NS_G:    count_nxt = CNT_NS_G;
      NS_Y:    count_nxt = CNT_Y;
      EW_G:    count_nxt = CNT_EW_G;
      EW_Y:    count_nxt = CNT_Y;
      NIGHT:   count_nxt = 6'd0;
      default: count_nxt = CNT_RED;
    endcase
  end

  // NOTE: registers take non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_N) begin
    if (!rst_N) begin
      state     <= IDLE;
      count_num <= CNT_RED;
      blink     <= 1'b0;
    end else begin
      state     <= state_nxt;
      count_num <= count_nxt;
      blink     <= blink_nxt;
    end
  end

  tl_lamp_decode u_lamp_decode (
    .state    (3'(state)),
    .blink    (blink),
    .light_ns (light_ns),
    .light_ew (light_ew)
  );

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Bench for traffic_phase_ctrl with a behavioural countdown timer model and
// a phase-transition scoreboard.
module tb_traffic_phase_ctrl;
  import tl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_N;
  logic       run;
  logic       night_mode;
  logic       flag_re;
  logic       timer_en;
  logic [5:0] count_num;
  logic [2:0] light_ns;
  logic [2:0] light_ew;
  logic [2:0] phase;

  logic       force_flag;
  logic [5:0] tcount;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    state_t ph;
    int     dwell;
  } exp_t;

  exp_t sbq[$];
  bit   sb_en = 1'b0;

  logic [2:0] last_phase = 3'd0;
  int neg_cnt     = 0;
  int last_change = 0;
  int ar_a_stamp  = 0;
  bit ar_a_seen   = 1'b0;
  int period      = 0;

  always #5 clk = ~clk;

  traffic_phase_ctrl dut (
    .clk        (clk),
    .rst_N      (rst_N),
    .run        (run),
    .night_mode (night_mode),
    .flag_re    (flag_re),
    .timer_en   (timer_en),
    .count_num  (count_num),
    .light_ns   (light_ns),
    .light_ew   (light_ew),
    .phase      (phase)
  );

  // Companion countdown timer: preloads while disabled, counts down when
  // enabled and reloads one edge after reaching 0.
  always_ff @(posedge clk or negedge rst_N) begin
    if (!rst_N)               tcount <= 6'd0;
    else if (!timer_en)       tcount <= count_num;
    else if (tcount == 6'd0)  tcount <= count_num;
    else                      tcount <= tcount - 6'd1;
  end

  assign flag_re = force_flag | (tcount == 6'd1);

  function automatic logic [2:0] m_ns(input state_t s);
    case (s)
      NS_G:    return 3'b001;
      NS_Y:    return 3'b010;
      NIGHT:   return 3'b000;
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic [2:0] m_ew(input state_t s);
    case (s)
      EW_G:    return 3'b001;
      EW_Y:    return 3'b010;
      NIGHT:   return 3'b000;
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic [5:0] m_cnt(input state_t s);
    case (s)
      NS_G:        return 6'd30;
      EW_G:        return 6'd20;
      NS_Y, EW_Y:  return 6'd3;
      NIGHT:       return 6'd0;
      default:     return 6'd2;
    endcase
  endfunction

  function automatic logic m_en(input state_t s);
    return s inside {AR_A, NS_G, NS_Y, AR_B, EW_G, EW_Y};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input state_t s, input int dwell);
    exp_t e;
    e.ph    = s;
    e.dwell = dwell;
    sbq.push_back(e);
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (sbq.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(tag, 32'(sbq.size()), 32'd0);
    sbq.delete();
  endtask

  // Monitor: lamp invariants every cycle, scoreboard on each phase change.
  always @(negedge clk) begin
    exp_t e;
    neg_cnt++;
    check("inv_ns_onehot", 32'($onehot0(light_ns)), 32'd1);
    check("inv_ew_onehot", 32'($onehot0(light_ew)), 32'd1);
    check("inv_not_both_green", 32'(light_ns[0] & light_ew[0]), 32'd0);
    if (phase !== 3'(NIGHT))
      check("inv_no_both_go", 32'((|light_ns[1:0]) & (|light_ew[1:0])), 32'd0);
    if (phase !== last_phase) begin
      if (sb_en) begin
        if (sbq.size() == 0) begin
          check("unexpected_phase_change", 32'(phase), 32'(last_phase));
        end else begin
          e = sbq.pop_front();
          check("sb_phase", 32'(phase), 32'(e.ph));
          check("sb_timer_en", 32'(timer_en), 32'(m_en(e.ph)));
          check("sb_count_num", 32'(count_num), 32'(m_cnt(e.ph)));
          check("sb_light_ns", 32'(light_ns), 32'(m_ns(e.ph)));
          check("sb_light_ew", 32'(light_ew), 32'(m_ew(e.ph)));
          if (e.dwell >= 0) check("sb_dwell", 32'(neg_cnt - last_change), 32'(e.dwell));
        end
      end
      if (phase == 3'(AR_A)) begin
        if (ar_a_seen) period = neg_cnt - ar_a_stamp;
        ar_a_stamp = neg_cnt;
        ar_a_seen  = 1'b1;
      end
      last_phase  = phase;
      last_change = neg_cnt;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_N      = 1'b0;
    run        = 1'b0;
    night_mode = 1'b0;
    force_flag = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_phase", 32'(phase), 32'(IDLE));
    check("rst_timer_en", 32'(timer_en), 32'd0);
    check("rst_count_num", 32'(count_num), 32'd2);
    check("rst_light_ns", 32'(light_ns), 32'b100);
    check("rst_light_ew", 32'(light_ew), 32'b100);
    rst_N = 1'b1;
    sb_en = 1'b1;

    // Reload flag while the timer is disabled must not move the phase.
    force_flag = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("idle_flag_phase", 32'(phase), 32'(IDLE));
    check("idle_flag_en", 32'(timer_en), 32'd0);
    force_flag = 1'b0;

    // Two full cycles from IDLE; dwell is the length of the phase just left.
    run = 1'b1;
    push(AR_A, -1);
    push(NS_G, 2);
    for (int c = 0; c < 2; c++) begin
      push(NS_Y, 31);
      push(AR_B, 4);
      push(EW_G, 3);
      push(EW_Y, 21);
      push(AR_A, 4);
      push(NS_G, 3);
    end
    drain("drain_cycle", 250);
    check("cycle_period", 32'(period), 32'd66);

    // Night mode mid NS_G.
    repeat (10) @(negedge clk);
    #1;
    night_mode = 1'b1;
    push(NIGHT, -1);
    drain("drain_night", 1);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      #1;
      check("night_timer_en", 32'(timer_en), 32'd0);
      check("night_count", 32'(count_num), 32'd0);
      check("night_ns", 32'(light_ns), (i % 2 == 1) ? 32'b010 : 32'b000);
      check("night_ew", 32'(light_ew), (i % 2 == 1) ? 32'b010 : 32'b000);
    end
    night_mode = 1'b0;
    push(AR_A, -1);
    push(NS_G, 3);
    drain("drain_night_release", 10);

    // A single forced reload flag in NS_G gives exactly one advance.
    repeat (5) @(negedge clk);
    #1;
    force_flag = 1'b1;
    push(NS_Y, -1);
    @(negedge clk);
    #1;
    force_flag = 1'b0;
    drain("drain_pulse", 2);
    repeat (10) @(negedge clk);
    #1;
    check("pulse_single_advance", 32'(phase), 32'(NS_Y));
    push(AR_B, -1);
    push(EW_G, 3);
    push(EW_Y, 21);
    drain("drain_to_ew_y", 100);

    // run=0 in EW_Y, then night_mode with run=0.
    @(negedge clk);
    #1;
    run = 1'b0;
    push(IDLE, -1);
    drain("drain_run_off", 1);
    night_mode = 1'b1;
    push(NIGHT, -1);
    drain("drain_night_over_idle", 1);
    night_mode = 1'b0;
    run = 1'b1;
    push(AR_A, -1);
    push(NS_G, 3);
    push(NS_Y, 31);
    push(AR_B, 4);
    push(EW_G, 3);
    drain("drain_to_ew_g", 100);

    // Asynchronous reset in the middle of EW_G, away from any clock edge.
    repeat (5) @(negedge clk);
    sb_en = 1'b0;
    #2;
    rst_N = 1'b0;
    #1;
    check("async_rst_phase", 32'(phase), 32'(IDLE));
    check("async_rst_timer_en", 32'(timer_en), 32'd0);
    check("async_rst_count", 32'(count_num), 32'd2);
    check("async_rst_ns", 32'(light_ns), 32'b100);
    check("async_rst_ew", 32'(light_ew), 32'b100);
    run = 1'b0;
    repeat (2) @(negedge clk);
    rst_N = 1'b1;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
